// File: rtl/hazard_detect_if.sv
// Issue-side interlock bundle: ID-stage operand/producer info and flush in,
// pipeline write enables, bubble, stall flag and stall-cycle counter out.
interface hazard_detect_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       id_rs;
  logic [1:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [1:0]       id_dest;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_valid;
  logic             flush;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
           id_regwrite, id_memread, id_valid, flush,
    input  pc_write, ifid_write, idex_bubble, stall, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
           id_regwrite, id_memread, id_valid, flush,
    output pc_write, ifid_write, idex_bubble, stall, stall_count
  );
endinterface

// File: rtl/hazard_detect.sv
// Pipeline interlock: shadows EX/MEM destinations and stalls ID on unresolved sources.
// HAZARD_FORWARDING_EN defined: only load-use on EX stalls; undefined: any EX/MEM producer stalls.
module hazard_detect #(
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  hazard_detect_if.slave  hz
);

  logic             ex_valid_q, ex_valid_d;
  logic [1:0]       ex_dest_q, ex_dest_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic             ex_memread_q, ex_memread_d;
  logic             mem_valid_q, mem_valid_d;
  logic [1:0]       mem_dest_q, mem_dest_d;
  logic             mem_regwrite_q, mem_regwrite_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic hazard, stall, bubble;

  always_comb begin
    rs_ex  = ex_valid_q  & ex_regwrite_q  & hz.id_use_rs & (hz.id_rs == ex_dest_q);
    rt_ex  = ex_valid_q  & ex_regwrite_q  & hz.id_use_rt & (hz.id_rt == ex_dest_q);
    rs_mem = mem_valid_q & mem_regwrite_q & hz.id_use_rs & (hz.id_rs == mem_dest_q);
    rt_mem = mem_valid_q & mem_regwrite_q & hz.id_use_rt & (hz.id_rt == mem_dest_q);
`ifdef HAZARD_FORWARDING_EN
    hazard = hz.id_valid & ex_memread_q & (rs_ex | rt_ex);
`else
    hazard = hz.id_valid & (rs_ex | rt_ex | rs_mem | rt_mem);
`endif
    // A squashed instruction must never hold up the fetch redirect.
    stall  = hazard & ~hz.flush;
    bubble = stall | hz.flush;
  end

  always_comb begin
    mem_valid_d    = ex_valid_q;
    mem_dest_d     = ex_dest_q;
    mem_regwrite_d = ex_regwrite_q;
    ex_valid_d     = bubble ? 1'b0 : hz.id_valid;
    ex_dest_d      = bubble ? ex_dest_q : hz.id_dest;
    ex_regwrite_d  = bubble ? ex_regwrite_q : hz.id_regwrite;
    ex_memread_d   = bubble ? ex_memread_q : hz.id_memread;
    cnt_d          = stall ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_dest_q      <= 2'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_dest_q     <= 2'd0;
      mem_regwrite_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_dest_q      <= ex_dest_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_valid_q    <= mem_valid_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      cnt_q          <= cnt_d;
    end
  end

  assign hz.stall       = stall;
  assign hz.pc_write    = ~stall;
  assign hz.ifid_write  = ~stall;
  assign hz.idex_bubble = bubble;
  assign hz.stall_count = cnt_q;

endmodule

// File: doc/hazard_detect.md
# hazard_detect

Pipeline interlock for the 5-stage CPU and the issue-side counterpart of the EX-stage forwarding selector. It shadows the destination registers of instructions in EX and MEM. When an instruction in ID needs a source that forwarding cannot supply, it stalls PC and IF/ID and inserts a bubble into ID/EX. It also counts stall cycles for performance measurement.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_rs`  in  2  source register 1 of the instruction in ID.
- `id_rt`  in  2  source register 2 of the instruction in ID.
- `id_use_rs`  in  1  the ID instruction actually reads `id_rs`.
- `id_use_rt`  in  1  the ID instruction actually reads `id_rt`.
- `id_dest`  in  2  destination register of the ID instruction.
- `id_regwrite`  in  1  the ID instruction writes the register file.
- `id_memread`  in  1  the ID instruction is a load.
- `id_valid`  in  1  ID holds a real instruction, not a bubble.
- `flush`  in  1  taken branch or jump resolved in EX; squash the ID instruction.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID register write enable.
- `idex_bubble`  out  1  force the ID/EX control fields to NOP.
- `stall`  out  1  a hazard stall is active this cycle.
- `stall_count`  out  `CNT_W`  stall cycles since reset; wraps.

## Operation
- Shadow state consists of two slots:
  - EX slot: `ex_valid`, `ex_dest`, `ex_regwrite`, `ex_memread`.
  - MEM slot: `mem_valid`, `mem_dest`, `mem_regwrite`.
- The register file is write-through, so a producer in WB never causes a hazard.
- A source matches a slot when all of these hold: the slot's valid bit, the slot's regwrite bit, the source's use bit, and the source register equals the slot's dest.
- `hazard` is `id_valid` AND (rs match OR rt match) under the active rule; see Configuration.
- `stall` = `hazard` AND NOT `flush`.
- Outputs:
  - `pc_write` = NOT `stall`.
  - `ifid_write` = NOT `stall`.
  - `idex_bubble` = `stall` OR `flush`.
- Per-edge update:
  - MEM slot takes the EX slot.
  - If `idex_bubble`, the EX slot's valid bit is cleared.
  - Otherwise the EX slot loads the `id_*` fields, with valid set to `id_valid`.
- `stall_count` increments by 1 modulo 2^`CNT_W` on each edge where `stall` is high.
- `flush` has priority over `hazard`. The squashed instruction must not stall the pipe, because the fetch redirect has to proceed.
- Register 0 is an ordinary register. There is no zero-register exemption.

## Timing
- All outputs are combinational from the shadow state and the current `id_*`/`flush` inputs. The internal state latency is one cycle.
- Reset (synchronous), effective on the following cycle:
  - Both valid bits clear.
  - `stall_count` = 0.
  - `stall` = 0, `pc_write` = 1, `ifid_write` = 1, `idex_bubble` = `flush`.
- With forwarding, a load-use hazard costs exactly 1 stall cycle. The bubble then occupies EX, and the load in MEM is forwarded afterward.
- Without forwarding:
  - A dependent instruction immediately behind its producer stalls 2 cycles.
  - With one independent instruction between them, it stalls 1 cycle.
- Reset asserted mid-stall: the next cycle has no stall and empty slots, regardless of the `id_*` inputs.
- Both sources matching different slots in the same cycle is still one stall cycle per cycle; counts do not double.
- A counter at the all-ones value wraps to 0 on the next stall edge.

## Configuration
- Macro: `HAZARD_FORWARDING_EN`.
- Defined: the only hazard is a match on the EX slot with `ex_memread` = 1. The MEM slot is ignored, because forwarding covers EX/MEM and MEM/WB.
- Undefined: the hazard is a match on the EX slot (any regwrite instruction) or on the MEM slot. This is for the forwarding-less build; the forwarding selector is tied to select 0 there.

## Test plan
- Load-use, forwarding on: `LWD r1` followed by `ADD r2,r1,r3`.
  - The ADD cycle shows `stall`=1, `pc_write`=0, `idex_bubble`=1 for exactly 1 cycle.
  - `stall_count` goes 0->1.
  - The next cycle shows `stall`=0.
- ALU-use, forwarding on: `ADD r1` then `ADD r2,r1` -> no stall, `stall_count` stays 0.
- ALU-use, forwarding off:
  - Back-to-back dependency -> 2 stall cycles.
  - Dependency with one independent instruction between -> 1 stall cycle.
  - `stall_count`=3 afterward.
- Flush during hazard: load-use condition with `flush`=1 -> `stall`=0, `pc_write`=1, `idex_bubble`=1, `stall_count` unchanged.
- Unused source: EX holds `LWD r2`; ID has `id_rt`=2 with `id_use_rt`=0 -> no stall.
- Reset and wrap:
  - Preload the counter to 0xFFFF via stalls, with `CNT_W`=16; one more stall -> 0x0000.
  - Assert `reset` during a stall -> the next cycle has `stall`=0 and `stall_count`=0.
